// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants and types for the SPI slave front-end.
//   FRAME_BITS / TX_BITS     : frame and transmit payload widths
//   TX_STATUS_FULL / _EMPTY  : status byte sent first on MISO
//   CNT_FULL / CNT_SAT       : bit-counter value of a good frame / saturation
//   frame_state_t            : frame tracking FSM states
//   byte_swap32()            : wire byte order -> rd_data byte order
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  localparam int FRAME_BITS = 32;
  localparam int TX_BITS    = 24;

  localparam logic [7:0] TX_STATUS_FULL  = 8'h01;
  localparam logic [7:0] TX_STATUS_EMPTY = 8'h00;

  localparam int                CNT_W    = 6;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_t;

  // The RX shifter holds byte0 in its top byte; the decoder wants byte0 in [7:0].
  function automatic logic [FRAME_BITS-1:0] byte_swap32(input logic [FRAME_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// STAGES-deep synchronizer for an asynchronous input with single-cycle edge
// pulses derived from the synchronized value.
// Parameters: STAGES (>= 2), RST_VAL (idle level the chain resets to)
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   din        : asynchronous input
//   rise, fall : one-cycle pulses on synchronized rising / falling edges
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_p;
  logic              prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p <= {STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], din};
      prev   <= sync_p[STAGES-1];
    end
  end

  assign rise = sync_p[STAGES-1] & ~prev;
  assign fall = ~sync_p[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI mode-0 slave, fully oversampled in the clk domain (clk >= 8x SCK).
// Receives 32-bit frames into rd_data (valid/ack handshake) and returns a
// 24-bit payload, loaded through a one-word holding buffer, on the next frame.
// Optional build macro: SPI_SLAVE_DEBUG_LED_EN drives LED_Groups; otherwise
// LED_Groups is tied to zero.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   SPI_SCK/SS/MOSI   : SPI pins in (SS active low)
//   SPI_MISO          : SPI data out, 0 while not selected
//   wr_buffer_free    : holding buffer empty
//   wr_en, wr_data    : load transmit payload (only when free)
//   rd_data_available : rd_data holds an unacknowledged frame
//   rd_ack            : consume the received frame
//   rd_data           : last complete frame, opcode in [7:0]
//   LED_Groups        : debug indicators
// -----------------------------------------------------------------------------
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SPI_SCK,
  input  logic                  SPI_SS,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  wr_buffer_free,
  input  logic                  wr_en,
  input  logic [TX_BITS-1:0]    wr_data,
  output logic                  rd_data_available,
  input  logic                  rd_ack,
  output logic [FRAME_BITS-1:0] rd_data,
  output logic [3:0]            LED_Groups
);

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_p;
  logic                   mosi_bit;

  frame_state_t state, state_nxt;
  logic         frame_start, frame_ok;

  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] rx_shift, tx_shift;
  logic [TX_BITS-1:0]    hold_data;
  logic                  hold_full;
  logic                  rd_avail, refresh;

  // ---- input synchronization --------------------------------------------
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(SPI_SCK), .rise(sck_rise), .fall(sck_fall)
  );

  // SS idles high, so its chain resets high to avoid a spurious frame end.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .reset(reset), .din(SPI_SS), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_p <= '0;
    else       mosi_p <= {mosi_p[SYNC_STAGES-2:0], SPI_MOSI};
  end
  assign mosi_bit = mosi_p[SYNC_STAGES-1];

  // ---- frame tracking FSM -----------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_ok    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_nxt   = ST_FRAME;
          frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        if (ss_rise) begin
          state_nxt = ST_IDLE;
          frame_ok  = (bit_cnt == CNT_FULL);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- shift registers and bit counter ----------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (frame_start) begin
      bit_cnt  <= '0;
      // Wire order is status, wr_data[23:16], [15:8], [7:0], MSB first.
      tx_shift <= hold_full ? {TX_STATUS_FULL, hold_data}
                            : {TX_STATUS_EMPTY, {TX_BITS{1'b0}}};
    end else if (state == ST_FRAME) begin
      if (sck_rise) begin
        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_bit};
        // Saturate one past a full frame so overlong frames never match.
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (sck_fall) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  // ---- transmit holding buffer ------------------------------------------
  // A write landing on the frame-start cycle refills the buffer just as the
  // old word moves into the TX shifter, so it is accepted even when full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (wr_en && (!hold_full || frame_start)) begin
      hold_data <= wr_data;
      hold_full <= 1'b1;
    end else if (frame_start) begin
      hold_full <= 1'b0;
    end
  end

  // ---- receive handshake ------------------------------------------------
  // Overwriting an unacknowledged frame drops available for one cycle
  // (refresh) so an edge-triggered consumer sees a new rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_avail <= 1'b0;
      refresh  <= 1'b0;
    end else if (frame_ok) begin
      rd_data  <= byte_swap32(rx_shift);
      rd_avail <= ~rd_avail;
      refresh  <= rd_avail;
    end else if (refresh) begin
      rd_avail <= 1'b1;
      refresh  <= 1'b0;
    end else if (rd_ack) begin
      rd_avail <= 1'b0;
    end
  end

  assign rd_data_available = rd_avail;
  assign wr_buffer_free    = ~hold_full;
  assign SPI_MISO          = (state == ST_FRAME) & tx_shift[FRAME_BITS-1];

`ifdef SPI_SLAVE_DEBUG_LED_EN
  logic led_toggle;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         led_toggle <= 1'b0;
    else if (frame_ok) led_toggle <= ~led_toggle;
  end
  assign LED_Groups = {led_toggle, hold_full, rd_avail, (state == ST_FRAME)};
`else
  assign LED_Groups = 4'b0000;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
// Directed bench for spi_slave_core: a mode-0 SPI master model (SCK = clk/16)
// drives frames with hand-computed expected rd_data and MISO words.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

  localparam int HALF = 8;  // clk cycles per SCK half period

  logic        clk = 1'b0;
  logic        reset;
  logic        SPI_SCK, SPI_SS, SPI_MOSI, SPI_MISO;
  logic        wr_buffer_free, wr_en, rd_data_available, rd_ack;
  logic [23:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  LED_Groups;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_valid = 0;
  int          zeros;
  logic [31:0] miso_w;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .SPI_SCK(SPI_SCK), .SPI_SS(SPI_SS), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .wr_buffer_free(wr_buffer_free), .wr_en(wr_en), .wr_data(wr_data),
    .rd_data_available(rd_data_available), .rd_ack(rd_ack), .rd_data(rd_data),
    .LED_Groups(LED_Groups)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic ss_low();
    SPI_SS = 1'b0;
    tick(HALF);
  endtask

  // Sends n bits MSB first from word (bits past 32 are zero); MISO is
  // sampled just before each SCK rise, as a mode-0 master does.
  task automatic send_bits(input logic [31:0] word, input int n, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = (i < 32) ? word[31-i] : 1'b0;
      tick(HALF);
      if (i < 32) miso = {miso[30:0], SPI_MISO};
      SPI_SCK = 1'b1;
      tick(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  // Raises SS and counts cycles with available low in the window after it.
  task automatic ss_high(output int low_cnt);
    tick(HALF);
    SPI_SS = 1'b1;
    low_cnt = 0;
    repeat (12) begin
      tick(1);
      if (!rd_data_available) low_cnt++;
    end
  endtask

  task automatic do_frame(input logic [31:0] word, input int n, output logic [31:0] miso,
                          output int low_cnt);
    ss_low();
    send_bits(word, n, miso);
    ss_high(low_cnt);
  endtask

  task automatic wr_pulse(input logic [23:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
    tick(1);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; SPI_SCK = 1'b0; SPI_SS = 1'b1; SPI_MOSI = 1'b0;
    wr_en = 1'b0; wr_data = '0; rd_ack = 1'b0;
    tick(4);
    check_val("rst_miso",  {31'd0, SPI_MISO}, 32'd0);
    check_val("rst_free",  {31'd0, wr_buffer_free}, 32'd1);
    check_val("rst_avail", {31'd0, rd_data_available}, 32'd0);
    check_val("rst_rdata", rd_data, 32'd0);
    check_val("rst_led",   {28'd0, LED_Groups}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Reset in the middle of a frame with a word pending in the buffer.
    ss_low();
    send_bits(32'hFFFF_FFFF, 10, miso_w);
    wr_pulse(24'h777777);
    check_val("mid_free_before", {31'd0, wr_buffer_free}, 32'd0);
    reset = 1'b1;
    tick(2);
    check_val("mid_rst_free",  {31'd0, wr_buffer_free}, 32'd1);
    check_val("mid_rst_miso",  {31'd0, SPI_MISO}, 32'd0);
    check_val("mid_rst_avail", {31'd0, rd_data_available}, 32'd0);
    reset = 1'b0;
    send_bits(32'hFFFF_FFFF, 10, miso_w);
    ss_high(zeros);
    check_val("mid_abandon_avail", {31'd0, rd_data_available}, 32'd0);
    check_val("mid_abandon_rdata", rd_data, 32'd0);

    // Receive 04 00 00 05 with an empty transmit buffer.
    do_frame(32'h0400_0005, 32, miso_w, zeros);
    n_valid++;
    check_val("rx_rdata", rd_data, 32'h0500_0004);
    check_val("rx_avail", {31'd0, rd_data_available}, 32'd1);
    check_val("rx_miso_empty", miso_w, 32'h0000_0000);
    ack_pulse();
    check_val("ack_avail", {31'd0, rd_data_available}, 32'd0);
    check_val("ack_rdata_hold", rd_data, 32'h0500_0004);

    // Transmit ABCDEF on the next frame.
    check_val("tx_free_before", {31'd0, wr_buffer_free}, 32'd1);
    wr_pulse(24'hABCDEF);
    check_val("tx_free_loaded", {31'd0, wr_buffer_free}, 32'd0);
    ss_low();
    check_val("tx_free_after_ss", {31'd0, wr_buffer_free}, 32'd1);
    send_bits(32'h0A0B_0C0D, 32, miso_w);
    ss_high(zeros);
    n_valid++;
    check_val("tx_miso", miso_w, 32'h01AB_CDEF);
    check_val("tx_rdata", rd_data, 32'h0D0C_0B0A);
    ack_pulse();
    do_frame(32'hDEAD_BEEF, 32, miso_w, zeros);
    n_valid++;
    check_val("tx_miso_next_zero", miso_w, 32'h0000_0000);
    check_val("tx_rdata2", rd_data, 32'hEFBE_ADDE);
    ack_pulse();

    // Short frame of 20 bits: discarded, buffer still consumed.
    wr_pulse(24'h13579B);
    ss_low();
    send_bits(32'h1234_5678, 20, miso_w);
    ss_high(zeros);
    check_val("short_rdata", rd_data, 32'hEFBE_ADDE);
    check_val("short_avail", {31'd0, rd_data_available}, 32'd0);
    check_val("short_free",  {31'd0, wr_buffer_free}, 32'd1);

    // Overwrite without ack: one-cycle gap on available.
    do_frame(32'h4433_2211, 32, miso_w, zeros);
    n_valid++;
    check_val("ovw_first", rd_data, 32'h1122_3344);
    do_frame(32'h8877_6655, 32, miso_w, zeros);
    n_valid++;
    check_val("ovw_gap_cycles", zeros, 32'd1);
    check_val("ovw_rdata", rd_data, 32'h5566_7788);
    check_val("ovw_avail", {31'd0, rd_data_available}, 32'd1);
    ack_pulse();

    // Second write while full is ignored.
    wr_pulse(24'h123456);
    wr_pulse(24'h654321);
    check_val("ign_free", {31'd0, wr_buffer_free}, 32'd0);
    do_frame(32'h0102_0304, 32, miso_w, zeros);
    n_valid++;
    check_val("ign_miso", miso_w, 32'h0112_3456);
    check_val("ign_rdata", rd_data, 32'h0403_0201);
    ack_pulse();

    // 34 SCK edges: counter saturates, frame discarded.
    do_frame(32'hCAFE_F00D, 34, miso_w, zeros);
    check_val("long_rdata", rd_data, 32'h0403_0201);
    check_val("long_avail", {31'd0, rd_data_available}, 32'd0);

    // Ack with nothing available has no effect.
    ack_pulse();
    check_val("idle_ack_avail", {31'd0, rd_data_available}, 32'd0);

`ifdef SPI_SLAVE_DEBUG_LED_EN
    check_val("led_toggle", {31'd0, LED_Groups[3]}, {31'd0, n_valid[0]});
    check_val("led_ss",     {31'd0, LED_Groups[0]}, 32'd0);
`else
    check_val("led_off", {28'd0, LED_Groups}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
